// File: rtl/uart_pkg.sv
// Shared UART definitions for the SoC receiver and transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and a registered occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, a receive FIFO and sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clear
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int TW         = $clog2(BIT_CYCLES + 1);
  localparam int IW         = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

  logic                      sync1;
  logic                      rxs;
  rx_state_e                 state, state_n;
  logic [TW-1:0]             timer, timer_n;
  logic [IW-1:0]             bit_idx, idx_n;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      sample_bit;
  logic                      push;
  logic                      frame_evt;
  logic                      ovr_evt;
  logic                      fifo_full;
  logic                      fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = (timer != '0) ? timer - TW'(1) : timer;
    idx_n      = bit_idx;
    sample_bit = 1'b0;
    push       = 1'b0;
    frame_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          timer_n = HALF_M1;
          state_n = START;
        end
      end
      START: begin
        if (timer == '0) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            timer_n = BIT_M1;
            idx_n   = '0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (timer == '0) begin
          sample_bit = 1'b1;
          timer_n    = BIT_M1;
          if (bit_idx == LAST_IDX) state_n = STOP;
          else                     idx_n   = bit_idx + IW'(1);
        end
      end
      STOP: begin
        if (timer == '0) begin
          if (rxs) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            frame_evt = 1'b1;
            state_n   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Data bits are only meaningful once a full frame is pushed, so no reset here.
  always_ff @(posedge clk) begin
    if (sample_bit) shreg[bit_idx] <= rxs;
  end

  // A full FIFO drops the byte only when the reader is not popping that cycle.
  assign ovr_evt = push && fifo_full && !rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_evt)      frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (ovr_evt)        overrun   <= 1'b1;
      else if (err_clear) overrun   <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (shreg),
    .pop     (rd_ready),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (rd_data)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: a default-rate instance for timing/glitch, a fast instance for FIFO and error cases.
module tb_uart_rx_fifo;

  localparam int BC_A   = 100_000_000 / 115200;
  localparam int HALF_A = BC_A / 2;
  localparam int BC_B   = 1_600_000 / 100_000;
  localparam int HALF_B = BC_B / 2;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       rx_a, rx_b;
  logic       rd_ready_a, rd_ready_b;
  logic       err_clear_a, err_clear_b;
  logic       rd_valid_a, rd_valid_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic [4:0] count_a, count_b;
  logic       frame_err_a, frame_err_b;
  logic       overrun_a, overrun_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_a   = -1;
  logic prev_a = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_valid_a && !prev_a) rise_a = cyc;
    prev_a = rd_valid_a;
  end

  uart_rx_fifo u_dut_a (
    .clk(clk), .rst(rst_a), .rx_i(rx_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a),
    .rd_ready(rd_ready_a), .fifo_count(count_a), .frame_err(frame_err_a),
    .overrun(overrun_a), .err_clear(err_clear_a)
  );

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(16)) u_dut_b (
    .clk(clk), .rst(rst_b), .rx_i(rx_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .rd_ready(rd_ready_b), .fifo_count(count_b), .frame_err(frame_err_b),
    .overrun(overrun_b), .err_clear(err_clear_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  // Frame with chosen stop bit; a 0 stop leaves the line low for the caller.
  task automatic send(input bit which, input logic [7:0] b, input logic stop_bit);
    int bc;
    bc = which ? BC_B : BC_A;
    drive(which, 1'b0);
    wait_cyc(bc);
    for (int i = 0; i < 8; i++) begin
      drive(which, b[i]);
      wait_cyc(bc);
    end
    drive(which, stop_bit);
    wait_cyc(bc);
    if (stop_bit) begin
      drive(which, 1'b1);
      wait_cyc(2);
    end
  endtask

  task automatic pop_b(input string tag, input logic [7:0] exp);
    check_eq(tag, rd_data_b, exp);
    rd_ready_b = 1'b1;
    wait_cyc(1);
    rd_ready_b = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    rst_a = 1'b1; rst_b = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1;
    rd_ready_a = 1'b0; rd_ready_b = 1'b0;
    err_clear_a = 1'b0; err_clear_b = 1'b0;
    wait_cyc(3);
    check_eq("rst_valid", rd_valid_a, 0);
    check_eq("rst_data", rd_data_a, 0);
    check_eq("rst_count", count_a, 0);
    check_eq("rst_flags", {frame_err_a, overrun_a}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    wait_cyc(3);

    // Two frames at the default rate, with rd_valid latency measured from the start bit.
    c0 = cyc;
    send(0, 8'h55, 1'b1);
    check_eq("valid_latency", rise_a - c0, HALF_A + 9 * BC_A + 3);
    check_eq("cnt1", count_a, 1);
    check_eq("head55", rd_data_a, 8'h55);
    send(0, 8'hA3, 1'b1);
    check_eq("cnt2", count_a, 2);
    check_eq("head55_b", rd_data_a, 8'h55);
    rd_ready_a = 1'b1; wait_cyc(1); rd_ready_a = 1'b0;
    check_eq("cnt1_pop", count_a, 1);
    check_eq("headA3", rd_data_a, 8'hA3);
    rd_ready_a = 1'b1; wait_cyc(1); rd_ready_a = 1'b0;
    check_eq("cnt0_pop", count_a, 0);
    check_eq("valid0", rd_valid_a, 0);
    check_eq("flags_a", {frame_err_a, overrun_a}, 0);

    // Short low pulse must not start a frame.
    rx_a = 1'b0; wait_cyc(300); rx_a = 1'b1; wait_cyc(1000);
    check_eq("glitch_cnt", count_a, 0);
    check_eq("glitch_ferr", frame_err_a, 0);
    send(0, 8'h0F, 1'b1);
    check_eq("post_glitch", rd_data_a, 8'h0F);
    check_eq("post_glitch_cnt", count_a, 1);

    // Framing error followed by a long break.
    send(1, 8'h3C, 1'b0);
    wait_cyc(5000);
    check_eq("ferr_set", frame_err_b, 1);
    check_eq("ferr_cnt", count_b, 0);
    rx_b = 1'b1; wait_cyc(20);
    check_eq("break_cnt", count_b, 0);
    send(1, 8'h7E, 1'b1);
    check_eq("rx7E_cnt", count_b, 1);
    pop_b("rx7E", 8'h7E);
    check_eq("ferr_sticky", frame_err_b, 1);
    err_clear_b = 1'b1; wait_cyc(1); err_clear_b = 1'b0;
    check_eq("ferr_clr", frame_err_b, 0);

    // Overrun: 17 bytes into a 16-entry FIFO.
    for (int i = 0; i <= 16; i++) send(1, 8'(i), 1'b1);
    check_eq("ovr_cnt", count_b, 16);
    check_eq("ovr_set", overrun_b, 1);
    check_eq("ovr_ferr", frame_err_b, 0);
    for (int i = 0; i < 16; i++) pop_b("ovr_data", 8'(i));
    check_eq("ovr_empty", rd_valid_b, 0);
    err_clear_b = 1'b1; wait_cyc(1); err_clear_b = 1'b0;
    check_eq("ovr_clr", overrun_b, 0);

    // Full FIFO with a pop landing exactly in the push cycle.
    for (int i = 0; i < 16; i++) send(1, 8'hB0 + 8'(i), 1'b1);
    check_eq("full_cnt", count_b, 16);
    fork
      send(1, 8'hC5, 1'b1);
      begin
        wait_cyc(HALF_B + 9 * BC_B + 2);
        rd_ready_b = 1'b1;
        wait_cyc(1);
        rd_ready_b = 1'b0;
      end
    join
    check_eq("simul_ovr", overrun_b, 0);
    check_eq("simul_cnt", count_b, 16);
    for (int i = 1; i < 16; i++) pop_b("simul_data", 8'hB0 + 8'(i));
    pop_b("simul_last", 8'hC5);
    check_eq("simul_empty", count_b, 0);

    // Async reset mid-frame with bytes buffered and a sticky flag set.
    send(1, 8'h11, 1'b1);
    send(1, 8'h22, 1'b1);
    send(1, 8'h33, 1'b1);
    send(1, 8'h44, 1'b0);
    rx_b = 1'b1; wait_cyc(20);
    check_eq("pre_rst_cnt", count_b, 3);
    check_eq("pre_rst_ferr", frame_err_b, 1);
    fork
      send(1, 8'h96, 1'b1);
      begin
        wait_cyc(HALF_B + 3 * BC_B);
        rst_b = 1'b1;
        #2;
        check_eq("arst_valid", rd_valid_b, 0);
        check_eq("arst_cnt", count_b, 0);
        check_eq("arst_data", rd_data_b, 0);
        check_eq("arst_flags", {frame_err_b, overrun_b}, 0);
      end
    join
    wait_cyc(1);
    rst_b = 1'b0;
    wait_cyc(5);
    send(1, 8'h81, 1'b1);
    check_eq("post_rst_cnt", count_b, 1);
    pop_b("post_rst_81", 8'h81);
    check_eq("post_rst_empty", rd_valid_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver peripheral for the SoC. It deserialises the board's UART_TXD_IN line (8N1, LSB first) and buffers received bytes in a small FIFO. It is the receive-side counterpart of the SoC UART transmitter that drives UART_RXD_OUT. The CPU-side peripheral wrapper pops bytes through a valid/ready read port and reads sticky framing-error and overrun flags.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, line rate; BIT_CYCLES = CLK_FREQ/BAUD (integer division) = 868 at defaults
FIFO_DEPTH, 16, receive buffer entries; must be a power of 2 and at least 2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx_i  in  1  serial line input, idle high, asynchronous to clk
rd_valid  out  1  FIFO not empty
rd_data  out  8  FIFO head byte; valid only while rd_valid=1
rd_ready  in  1  pop request; a byte is consumed when rd_valid && rd_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored bytes
frame_err  out  1  sticky: a stop bit was sampled as 0
overrun  out  1  sticky: a good byte was dropped because the FIFO was full
err_clear  in  1  clears frame_err and overrun

Behaviour:
- Reset: synchroniser flops = 1; FSM = IDLE; FIFO empty; rd_valid=0, rd_data=0, fifo_count=0, frame_err=0, overrun=0. Reset mid-frame aborts the frame and discards FIFO contents.
- rx_i passes through a 2-flop synchroniser (rxs). All sampling uses rxs.
- Bit timer: down-counter wide enough for BIT_CYCLES-1. HALF = BIT_CYCLES/2.
- IDLE: when rxs==0, load timer with HALF-1 and go to START.
- START: at timer==0, sample rxs.
  - rxs==1: glitch; return to IDLE, nothing recorded.
  - rxs==0: load timer with BIT_CYCLES-1, clear bit index, go to DATA.
- DATA: at each timer==0, shift rxs into bit[index] (LSB first) and reload the timer. After the 8th sample, go to STOP.
- STOP: at timer==0, sample rxs.
  - rxs==1: push the byte and go to IDLE.
  - rxs==0: set frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs==1, then go to IDLE. This covers line breaks without generating spurious frames.
- Sampling points fall at mid-bit. The push cycle occurs (HALF + 9*BIT_CYCLES) cycles after the start edge reaches rxs. rd_valid and fifo_count update on the clock edge after the push cycle.
- FIFO:
  - Registered read pointer and write pointer plus a count.
  - rd_data always shows the head entry. It is combinational from storage, and no read latency is added.
  - Pop while empty is ignored.
  - Push while full with no pop: the byte is dropped and overrun is set.
  - Push and pop in the same cycle while full: both take effect, count is unchanged, overrun stays unchanged.
  - Push and pop in the same cycle while empty: push only, since rd_valid was 0.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: err_clear clears both flags next cycle. If an error event and err_clear occur in the same cycle, the set wins.

Decomposition:
- Package uart_pkg: UART_DATA_BITS=8; the rx FSM state enum (IDLE, START, DATA, STOP, WAIT_IDLE); the bit_cycles(clk,baud) function. The matching transmitter will reuse this package.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), with ports push/pop/full/empty/count/head. uart_rx_fifo contains the synchroniser, timer, FSM and flag logic.

Test Plan:
- Send frame 0x55, then 0xA3, at BIT_CYCLES=868 -> rd_valid rises 1 cycle after the stop-sample cycle; rd_data=0x55 then 0xA3 after one pop; fifo_count goes 1,2,1,0; no flags set.
- Glitch: rx_i low for 300 cycles (< HALF=434), then high -> no push, FSM back in IDLE, fifo_count=0.
- Framing: send 0x3C with stop bit 0, then hold rx low for 5000 cycles, then high -> frame_err=1, fifo_count=0; the next valid frame 0x7E is received correctly; err_clear -> frame_err=0.
- Overrun: send 17 bytes 0x00..0x10 with rd_ready=0 -> fifo_count=16, overrun=1; popping returns 0x00..0x0F and 0x10 is lost.
- Full with simultaneous pop: FIFO full, hold rd_ready=1 exactly in the push cycle of byte 0xC5 -> overrun stays 0, count stays 16, 0xC5 is the last entry read.
- Async reset asserted mid-DATA of 0x96 with 3 bytes buffered -> all outputs 0 immediately; after release a new frame 0x81 is received as the only entry.
